// File: rtl/light_sequencer.sv
// ---------------------------------------------------------------------------
// light_sequencer
//
// Phase sequencer for the intersection controller. Owns the 6-bit cycle
// counter and the pedestrian-request latch, and steps a Moore state machine
// through the light phases on tick & enable. All lamp outputs are registered.
//
// Configuration macro: LIGHT_SEQ_FLASH_EN
//   undefined : watchdog expiry recovers to MG with counter cleared.
//   defined   : watchdog expiry enters S_FLASH (flashing yellow, reset-only exit).
//
// Parameters:
//   CNT_MAX     counter ceiling and watchdog threshold (must fit in 6 bits)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   tick        one-cycle time-base strobe
//   enable      phase-advance request (may be held many cycles)
//   ped_req     pedestrian button
//   counter     cycle counter to the timing-decision stage
//   PED         latched pedestrian request
//   main_light  main-road lamps, one-hot {red, yellow, green}
//   side_light  side-road lamps, one-hot {red, yellow, green}
//   walk        pedestrian walk lamp
//   fault       sticky watchdog flag
//   phase       current state encoding (debug)
// ---------------------------------------------------------------------------
module light_sequencer #(
  parameter int CNT_MAX = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       ped_req,
  output logic [5:0] counter,
  output logic       PED,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       fault,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_SG    = 3'd3,
    S_SY    = 3'd4,
    S_AR2   = 3'd5,
    S_WALK  = 3'd6
`ifdef LIGHT_SEQ_FLASH_EN
    ,
    S_FLASH = 3'd7
`endif
  } state_e;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;
  localparam logic [5:0] CntMax  = 6'(CNT_MAX);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       ped_q, ped_d;
  logic       fault_q, fault_d;
  logic [2:0] main_d, side_d;
  logic       walk_d;
  logic       advance, watchdog;
`ifdef LIGHT_SEQ_FLASH_EN
  logic       flash_on_q, flash_on_d;
`endif

  assign advance  = tick & enable;
  assign watchdog = tick & ~enable & (cnt_q == CntMax);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q;
    fault_d = fault_q;
`ifdef LIGHT_SEQ_FLASH_EN
    flash_on_d = flash_on_q;
`endif

    if (advance) begin
      unique case (state_q)
        S_MG:    state_d = S_MY;
        S_MY:    state_d = S_AR1;
        S_AR1:   state_d = S_SG;
        S_SG:    state_d = S_SY;
        S_SY:    state_d = S_AR2;
        // Decision uses the latch value registered before this edge.
        S_AR2:   state_d = ped_q ? S_WALK : S_MG;
        S_WALK:  state_d = S_MG;
        default: state_d = state_q;   // flash: enable ignored
      endcase
    end else if (watchdog) begin
      fault_d = 1'b1;
`ifdef LIGHT_SEQ_FLASH_EN
      state_d    = S_FLASH;
      flash_on_d = 1'b1;               // flashing starts lit
`else
      state_d = S_MG;
`endif
    end

    if (tick) begin
      if (watchdog || (advance && state_d == S_MG && state_q != S_MG)) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 6'd1;
      end
    end

`ifdef LIGHT_SEQ_FLASH_EN
    if (state_q == S_FLASH) begin
      state_d = S_FLASH;
      cnt_d   = '0;
      if (tick) flash_on_d = ~flash_on_q;
    end
`endif

    // Requests during WALK or on the AR2->WALK edge are dropped; entering
    // WALK consumes the pending request.
    if (advance && state_q == S_AR2 && ped_q) begin
      ped_d = 1'b0;
    end else if (state_q != S_WALK && ped_req) begin
      ped_d = 1'b1;
    end

    // Lamps are decoded from the next state so they register together
    // with it and change on the same edge.
    main_d = LampRed;
    side_d = LampRed;
    walk_d = 1'b0;
    unique case (state_d)
      S_MG:    main_d = LampGrn;
      S_MY:    main_d = LampYel;
      S_SG:    side_d = LampGrn;
      S_SY:    side_d = LampYel;
      S_WALK:  walk_d = 1'b1;
      default: ;                      // AR1 / AR2: all red
    endcase
`ifdef LIGHT_SEQ_FLASH_EN
    if (state_d == S_FLASH) begin
      main_d = flash_on_d ? LampYel : 3'b000;
      side_d = flash_on_d ? LampYel : 3'b000;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: reset is asynchronous, so outputs return to their reset values
    // as soon as reset falls, without waiting for a clock.
    if (!reset) begin
      state_q    <= S_MG;
      cnt_q      <= '0;
      ped_q      <= 1'b0;
      fault_q    <= 1'b0;
      main_light <= LampGrn;
      side_light <= LampRed;
      walk       <= 1'b0;
`ifdef LIGHT_SEQ_FLASH_EN
      flash_on_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_q      <= ped_d;
      fault_q    <= fault_d;
      main_light <= main_d;
      side_light <= side_d;
      walk       <= walk_d;
`ifdef LIGHT_SEQ_FLASH_EN
      flash_on_q <= flash_on_d;
`endif
    end
  end

  assign counter = cnt_q;
  assign PED     = ped_q;
  assign fault   = fault_q;
  assign phase   = state_q;

  // Outside flash: exactly one lamp per road, and at least one road red.
  a_one_lamp : assert property (@(posedge clk) disable iff (!reset)
    (phase != 3'd7) |-> ($onehot(main_light) && $onehot(side_light)));
  a_no_conflict : assert property (@(posedge clk) disable iff (!reset)
    (phase != 3'd7) |-> ((main_light == LampRed) || (side_light == LampRed)));

endmodule

// File: tb/tb_light_sequencer.sv
// ---------------------------------------------------------------------------
// tb_light_sequencer
//
// Self-checking bench for light_sequencer. A behavioural model (phase table,
// integer counter, pedestrian flag) is advanced every clock with the same
// inputs and compared against the DUT outputs one time unit after each edge.
// Honours LIGHT_SEQ_FLASH_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_light_sequencer;

  localparam int CNT_MAX = 63;
`ifdef LIGHT_SEQ_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       ped_req = 1'b0;
  logic [5:0] counter;
  logic       PED;
  logic [2:0] main_light, side_light, phase;
  logic       walk, fault;

  int checks = 0;
  int failures = 0;

  light_sequencer #(.CNT_MAX(CNT_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .enable     (enable),
    .ped_req    (ped_req),
    .counter    (counter),
    .PED        (PED),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .fault      (fault),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // {phase, counter, PED, main, side, walk, fault}
  logic [17:0] obs;
  assign obs = {phase, counter, PED, main_light, side_light, walk, fault};

  // ---------------- reference model ----------------
  int m_phase;
  int m_cnt;
  bit m_ped;
  bit m_fault;
  bit m_flash_on;

  // Normal sequence successor (AR2 and WALK handled separately).
  int succ [7] = '{1, 2, 3, 4, 5, 0, 0};

  function automatic logic [17:0] exp_vec();
    logic [2:0] mn, sd;
    logic w;
    mn = RED; sd = RED; w = 1'b0;
    case (m_phase)
      0: mn = GRN;
      1: mn = YEL;
      3: sd = GRN;
      4: sd = YEL;
      6: w = 1'b1;
      7: begin
        mn = m_flash_on ? YEL : 3'b000;
        sd = m_flash_on ? YEL : 3'b000;
      end
      default: ;
    endcase
    return {3'(m_phase), 6'(m_cnt), m_ped, mn, sd, w, m_fault};
  endfunction

  function automatic logic [17:0] reset_vec();
    return {3'd0, 6'd0, 1'b0, GRN, RED, 1'b0, 1'b0};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_ped = 0; m_fault = 0; m_flash_on = 0;
  endtask

  task automatic model_step(input bit t, input bit e, input bit p);
    int np, nc;
    bit nped;
    np = m_phase; nc = m_cnt; nped = m_ped;
    if (m_phase == 7) begin
      if (t) m_flash_on = !m_flash_on;
      nc = 0;
    end else if (t) begin
      if (e) begin
        if (m_phase == 5) np = m_ped ? 6 : 0;
        else np = succ[m_phase];
        if (np == 0) nc = 0;
        else nc = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end else if (m_cnt == CNT_MAX) begin
        m_fault = 1;
        nc = 0;
        if (FLASH) begin np = 7; m_flash_on = 1; end
        else np = 0;
      end else begin
        nc = m_cnt + 1;
      end
    end
    if (m_phase == 6) nped = m_ped;
    else if (t && e && m_phase == 5 && m_ped) nped = 0;
    else if (p) nped = 1;
    m_phase = np; m_cnt = nc; m_ped = nped;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 unit.
  task automatic step(input bit t, input bit e, input bit p);
    @(negedge clk);
    tick = t; enable = e; ped_req = p;
    @(posedge clk);
    model_step(t, e, p);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0; enable = 0; ped_req = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  function automatic bit en_at(input int c, input bit with39);
    return (c == 11 || c == 13 || c == 15 || c == 25 || c == 27 || c == 29 ||
            (with39 && c == 39));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== reset_vec()) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", obs, reset_vec());
    end
  endtask

  task automatic test_normal_cycle();
    int adv = 0;
    int n = 0;
    int prev;
    do_reset();
    while (adv < 6 && n < 200) begin
      prev = m_phase;
      step(1'b1, en_at(m_cnt, 1'b0), 1'b0);
      if (m_phase != prev) adv++;
      n++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL normal_cycle n=%0d: got %h want %h", n, obs, exp_vec());
      end
    end
    checks++;
    if (adv < 6 || phase !== 3'd0 || counter !== 6'd0) begin
      failures++;
      $display("FAIL normal_cycle_end: phase=%0d counter=%0d advances=%0d want 0/0/6",
               phase, counter, adv);
    end
  endtask

  task automatic test_hold_enable();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec() || phase !== 3'd0) begin
        failures++;
        $display("FAIL hold_no_tick i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec() || phase !== 3'd1) begin
      failures++;
      $display("FAIL hold_one_step: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_ped_walk();
    bit saw_walk = 0;
    int n = 0;
    do_reset();
    while (m_cnt != 5) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (PED !== 1'b1) begin
      failures++;
      $display("FAIL ped_latch: got PED=%b want 1", PED);
    end
    while (n < 200 && !(saw_walk && m_phase == 0)) begin
      step(1'b1, en_at(m_cnt, 1'b1), 1'b0);
      n++;
      if (m_phase == 6 && !saw_walk) begin
        saw_walk = 1;
        checks++;
        if (walk !== 1'b1 || PED !== 1'b0 || phase !== 3'd6 || counter !== 6'd30) begin
          failures++;
          $display("FAIL walk_entry: walk=%b PED=%b phase=%0d cnt=%0d want 1/0/6/30",
                   walk, PED, phase, counter);
        end
      end
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL ped_walk n=%0d: got %h want %h", n, obs, exp_vec());
      end
    end
    checks++;
    if (!saw_walk || phase !== 3'd0 || counter !== 6'd0) begin
      failures++;
      $display("FAIL walk_exit: phase=%0d counter=%0d want 0/0", phase, counter);
    end
  endtask

  task automatic test_ped_edges();
    int n = 0;
    do_reset();
    // Advance to AR2 with no request pending.
    while (n < 200 && !(m_phase == 5 && m_cnt == 29)) begin
      step(1'b1, en_at(m_cnt, 1'b0), 1'b0);
      n++;
    end
    step(1'b1, 1'b1, 1'b1);   // AR2 -> MG with a press on the same cycle
    checks++;
    if (phase !== 3'd0 || PED !== 1'b1) begin
      failures++;
      $display("FAIL ped_on_ar2_mg: phase=%0d PED=%b want 0/1", phase, PED);
    end
    n = 0;
    while (n < 200 && m_phase != 6) begin
      step(1'b1, en_at(m_cnt, 1'b0), 1'b0);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1);  // presses while walking are dropped
      checks++;
      if (PED !== 1'b0 || obs !== exp_vec()) begin
        failures++;
        $display("FAIL ped_in_walk i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL watchdog_run i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (fault !== 1'b1 || counter !== 6'd0) begin
      failures++;
      $display("FAIL watchdog_fire: fault=%b counter=%0d want 1/0", fault, counter);
    end
    checks++;
    if (FLASH) begin
      if (phase !== 3'd7 || main_light !== YEL || side_light !== YEL) begin
        failures++;
        $display("FAIL flash_entry: phase=%0d main=%b side=%b", phase, main_light, side_light);
      end
    end else if (phase !== 3'd0 || main_light !== GRN) begin
      failures++;
      $display("FAIL watchdog_mg: phase=%0d main=%b", phase, main_light);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0], 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL after_watchdog i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    while (n < 200 && m_phase != 3) begin
      step(1'b1, en_at(m_cnt, 1'b0), 1'b0);
      n++;
    end
    step(1'b1, 1'b0, 1'b1);   // sets PED so the reset has something to clear
    @(negedge clk);
    tick = 0; enable = 0; ped_req = 0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;                       // still well before the next rising edge
    checks++;
    if (obs !== reset_vec()) begin
      failures++;
      $display("FAIL async_reset: got %h want %h", obs, reset_vec());
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    bit t, e, p;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      t = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 15) == 0);
      step(t, e, p);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random i=%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    test_reset();
    test_normal_cycle();
    test_hold_enable();
    test_ped_walk();
    test_ped_edges();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
